// File: rtl/bf16_defs_pkg.sv
// Shared bfloat16 constants, field helpers and pipeline stage records for the bf16 MAC path.
// Used by bf16_mul_pipe and bf16_round_norm.
package bf16_defs_pkg;

  localparam logic signed [9:0] BF16_BIAS    = 10'sd127;
  localparam logic [15:0]       BF16_QNAN    = 16'h7FC0;
  localparam logic [15:0]       BF16_POS_INF = 16'h7F80;
  localparam logic [15:0]       BF16_MAX_FIN = 16'h7F7F;

  function automatic logic bf16_sign(input logic [15:0] v);
    return v[15];
  endfunction

  function automatic logic [7:0] bf16_exp(input logic [15:0] v);
    return v[14:7];
  endfunction

  function automatic logic [6:0] bf16_man(input logic [15:0] v);
    return v[6:0];
  endfunction

  // Product stage: sign, zero flag, unbiased exponent sum, raw 8x8 significand product.
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic signed [9:0] e_sum;
    logic [15:0]       prod;
  } s1_t;

  // Rounded stage: everything the pack step needs.
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic signed [9:0] e_adj;
    logic [6:0]        mant;
  } s2_t;

endpackage

// File: rtl/bf16_round_norm.sv
// Combinational normalise + round-to-nearest-even of a 16-bit significand product.
// Shared between the bf16 multiplier and adder.
module bf16_round_norm
  import bf16_defs_pkg::*;
(
  input  logic [15:0]       p,
  input  logic signed [9:0] e_sum,
  output logic [6:0]        mant,
  output logic signed [9:0] e_adj
);

  logic [6:0]        m_t;
  logic              g, r, st;
  logic signed [9:0] e_n;
  logic [7:0]        m_r;

  always_comb begin
    if (p[15]) begin
      m_t = p[14:8];
      g   = p[7];
      r   = p[6];
      st  = |p[5:0];
      e_n = e_sum + 10'sd1;
    end else begin
      m_t = p[13:7];
      g   = p[6];
      r   = p[5];
      st  = |p[4:0];
      e_n = e_sum;
    end
    // Round up above half, or at exactly half when the kept LSB is odd.
    m_r   = {1'b0, m_t} + {7'd0, g & (r | st | m_t[0])};
    mant  = m_r[6:0];
    e_adj = m_r[7] ? e_n + 10'sd1 : e_n;
  end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Pipelined bfloat16 multiplier y = x1*x2, one product per clock, latency 3 (2 with OUT_REG=0).
// Define BF16_NAN_INF_EN to build NaN/infinity handling; otherwise overflow saturates.
module bf16_mul_pipe
  import bf16_defs_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  output logic [15:0] y,
  output logic        ready
);

`ifdef BF16_NAN_INF_EN
  localparam logic [14:0] OVF_MAG = BF16_POS_INF[14:0];
`else
  localparam logic [14:0] OVF_MAG = BF16_MAX_FIN[14:0];
`endif

  logic        v0, v1, v2;
  logic [15:0] a0, b0;
  s1_t         s1_d, s1_q;
  s2_t         s2_q;
  logic [6:0]        rn_mant;
  logic signed [9:0] rn_e;
  logic [15:0] y_d;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  // NOTE: data registers are reset too, so y reads 0000 after reset even on the combinational output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
    end else begin
      v0 <= en;
      if (en) begin
        a0 <= x1;
        b0 <= x2;
      end
    end
  end

  always_comb begin
    s1_d.sign  = bf16_sign(a0) ^ bf16_sign(b0);
    s1_d.zero  = (bf16_exp(a0) == 8'd0) || (bf16_exp(b0) == 8'd0);
    s1_d.e_sum = $signed({2'b00, bf16_exp(a0)}) + $signed({2'b00, bf16_exp(b0)}) - BF16_BIAS;
    s1_d.prod  = {8'h00, 1'b1, bf16_man(a0)} * {8'h00, 1'b1, bf16_man(b0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else begin
      v1 <= v0;
      if (v0) s1_q <= s1_d;
    end
  end

  bf16_round_norm u_round_norm (
    .p     (s1_q.prod),
    .e_sum (s1_q.e_sum),
    .mant  (rn_mant),
    .e_adj (rn_e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      s2_q <= '0;
    end else begin
      v2 <= v1;
      if (v1) s2_q <= '{sign: s1_q.sign, zero: s1_q.zero, e_adj: rn_e, mant: rn_mant};
    end
  end

`ifdef BF16_NAN_INF_EN
  logic nan1, inf1, nan2, inf2;
  logic a_inf, b_inf, a_nan, b_nan;

  assign a_inf = (bf16_exp(a0) == 8'hFF) && (bf16_man(a0) == 7'd0);
  assign b_inf = (bf16_exp(b0) == 8'hFF) && (bf16_man(b0) == 7'd0);
  assign a_nan = (bf16_exp(a0) == 8'hFF) && (bf16_man(a0) != 7'd0);
  assign b_nan = (bf16_exp(b0) == 8'hFF) && (bf16_man(b0) != 7'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan1 <= 1'b0;
      inf1 <= 1'b0;
      nan2 <= 1'b0;
      inf2 <= 1'b0;
    end else begin
      if (v0) begin
        nan1 <= a_nan || b_nan || (a_inf && bf16_exp(b0) == 8'd0) ||
                (b_inf && bf16_exp(a0) == 8'd0);
        inf1 <= a_inf || b_inf;
      end
      if (v1) begin
        nan2 <= nan1;
        inf2 <= inf1;
      end
    end
  end
`endif

  // NOTE: every path of this always_comb assigns y_d, so no latch is inferred.
  always_comb begin
    if (s2_q.zero || s2_q.e_adj <= 10'sd0)
      y_d = {s2_q.sign, 15'h0000};
    else if (s2_q.e_adj >= 10'sd255)
      y_d = {s2_q.sign, OVF_MAG};
    else
      y_d = {s2_q.sign, s2_q.e_adj[7:0], s2_q.mant};
`ifdef BF16_NAN_INF_EN
    if (inf2) y_d = {s2_q.sign, BF16_POS_INF[14:0]};
    if (nan2) y_d = BF16_QNAN;
`endif
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic        v3;
      logic [15:0] y_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v3  <= 1'b0;
          y_q <= '0;
        end else begin
          v3 <= v2;
          if (v2) y_q <= y_d;
        end
      end
      assign y     = y_q;
      assign ready = v3;
    end else begin : g_out_comb
      // Stage-2 registers only load on valid data, so y still holds between products.
      assign y     = y_d;
      assign ready = v2;
    end
  endgenerate

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Scoreboard bench for bf16_mul_pipe: one instance per OUT_REG setting, shared stimulus,
// independent monitors checking value and latency of every product.
module tb_bf16_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] x1  = '0;
  logic [15:0] x2  = '0;
  logic [15:0] y3, y2;
  logic        r3, r2;

  bf16_mul_pipe #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2), .y(y3), .ready(r3)
  );

  bf16_mul_pipe #(.OUT_REG(1'b0)) dut_l2 (
    .clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2), .y(y2), .ready(r2)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [15:0] y;
    int          k;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;

  logic [15:0] va [14];
  logic [15:0] vb [14];
  logic [15:0] vy [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (r3) begin
        check("pending_l3", int'(q3.size() != 0), 1);
        if (q3.size() != 0) begin
          exp_t e;
          e = q3.pop_front();
          check("y_l3", int'(y3), int'(e.y));
          check("lat_l3", edge_cnt - e.k, 3);
        end
      end
      if (r2) begin
        check("pending_l2", int'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
          exp_t e;
          e = q2.pop_front();
          check("y_l2", int'(y2), int'(e.y));
          check("lat_l2", edge_cnt - e.k, 2);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int i);
    exp_t e;
    en  = 1'b1;
    x1  = va[i];
    x2  = vb[i];
    e.y = vy[i];
    e.k = edge_cnt + 1;
    q3.push_back(e);
    q2.push_back(e);
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic check_flushed(input string tag);
    check({tag, "_y_l3"}, int'(y3), 0);
    check({tag, "_rdy_l3"}, int'(r3), 0);
    check({tag, "_y_l2"}, int'(y2), 0);
    check({tag, "_rdy_l2"}, int'(r2), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0]  = 16'h4000; vb[0]  = 16'h4040; vy[0]  = 16'h40C0;
    va[1]  = 16'h4237; vb[1]  = 16'h3F80; vy[1]  = 16'h4237;
    va[2]  = 16'hBFC0; vb[2]  = 16'h4000; vy[2]  = 16'hC040;
    va[3]  = 16'h3F81; vb[3]  = 16'h3F81; vy[3]  = 16'h3F82;
    va[4]  = 16'h3FC0; vb[4]  = 16'h3F81; vy[4]  = 16'h3FC2;
    va[5]  = 16'h0000; vb[5]  = 16'h4237; vy[5]  = 16'h0000;
    va[6]  = 16'h8000; vb[6]  = 16'h4237; vy[6]  = 16'h8000;
    va[7]  = 16'h0080; vb[7]  = 16'h0080; vy[7]  = 16'h0000;
    va[8]  = 16'h7F00; vb[8]  = 16'h7F00;
    va[9]  = 16'h7F80; vb[9]  = 16'h0000;
    va[10] = 16'h7FC1; vb[10] = 16'h3F80;
    va[11] = 16'hFF80; vb[11] = 16'h4000;
`ifdef BF16_NAN_INF_EN
    vy[8]  = 16'h7F80;
    vy[9]  = 16'h7FC0;
    vy[10] = 16'h7FC0;
    vy[11] = 16'hFF80;
`else
    vy[8]  = 16'h7F7F;
    vy[9]  = 16'h0000;
    vy[10] = 16'h7F7F;
    vy[11] = 16'hFF7F;
`endif
    va[12] = 16'h3FFF; vb[12] = 16'h3FFF; vy[12] = 16'h407E;
    va[13] = 16'h3FC1; vb[13] = 16'h3FC1; vy[13] = 16'h4012;

    repeat (2) @(negedge clk);
    check_flushed("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Isolated products with gaps.
    for (int i = 0; i < 14; i++) begin
      issue(i);
      idle(4);
    end

    // Streaming: 8 back-to-back, one bubble, 2 more.
    for (int i = 0; i < 8; i++) issue(i);
    idle(1);
    issue(12);
    issue(13);
    idle(6);

    // Reset with two products in flight: neither may emerge.
    issue(0);
    issue(1);
    rst = 1'b1;
    q3.delete();
    q2.delete();
    repeat (3) begin
      @(negedge clk);
      check_flushed("midrst");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    check_flushed("postrst");
    issue(2);
    idle(6);

    for (int w = 0; w < 20 && (q3.size() != 0 || q2.size() != 0); w++) idle(1);
    check("drain_l3", q3.size(), 0);
    check("drain_l2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
